// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - state encoding and default sizes shared by the APB request arbiter
package apb_arb_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH  = 10;
    localparam int DEF_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/apb_rr_pick.sv
// rtl/apb_rr_pick.sv - two-way round-robin pick, one-hot grant
module apb_rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    // ptr only matters when both requesters contend
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester APB manager with round-robin arbitration and wait timeout
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [1:0]            req_i,
    input  logic [1:0]            wr_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic [1:0]            done_o,
    output logic [1:0]            err_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PWRITE,
    output logic                  PSELx,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t       state;
    logic             ptr;
    logic [1:0]       win;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       grant;

    apb_rr_pick u_pick (
        .req   (req_i),
        .ptr   (ptr),
        .grant (grant)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            win      <= 2'b00;
            wait_cnt <= '0;
            PSELx    <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            rdata_o  <= '0;
            done_o   <= 2'b00;
            err_o    <= 2'b00;
        end else begin
            done_o <= 2'b00;
            err_o  <= 2'b00;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        // operands are captured once here; later requester changes never reach the bus
                        win     <= grant;
                        PSELx   <= 1'b1;
                        PENABLE <= 1'b0;
                        if (grant[1]) begin
                            PADDR  <= addr1_i;
                            PWDATA <= wdata1_i;
                            PWRITE <= wr_i[1];
                        end else begin
                            PADDR  <= addr0_i;
                            PWDATA <= wdata0_i;
                            PWRITE <= wr_i[0];
                        end
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSELx   <= 1'b0;
                        PENABLE <= 1'b0;
                        done_o  <= win;
                        if (!PWRITE) begin
                            rdata_o <= PRDATA;
                        end
                        ptr   <= ~ptr;
                        state <= DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        // this wait cycle brings the count to the limit: abort straight to IDLE
                        PSELx    <= 1'b0;
                        PENABLE  <= 1'b0;
                        err_o    <= win;
                        ptr      <= ~ptr;
                        wait_cnt <= wait_cnt + 1'b1;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8, PWDATA/PRDATA width.
- ADDR_WIDTH, default 10, PADDR width.
- TIMEOUT_CYC, default 16, maximum PREADY-low ACCESS cycles before abort.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- PCLK  in  1  sole clock, rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- req_i  in  2  per-requester transfer request, bit i = requester i.
- wr_i  in  2  per-requester direction, 1 = write.
- addr0_i  in  ADDR_WIDTH  requester 0 address.
- addr1_i  in  ADDR_WIDTH  requester 1 address.
- wdata0_i  in  DATA_WIDTH  requester 0 write data.
- wdata1_i  in  DATA_WIDTH  requester 1 write data.
- done_o  out  2  one-cycle completion pulse, bit i = requester i.
- err_o  out  2  one-cycle timeout-abort pulse, bit i = requester i.
- rdata_o  out  DATA_WIDTH  last completed read data.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PWRITE  out  1  APB direction.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready; tie to 1 for zero-wait subordinates.

Function
REQ-003 The FSM SHALL have four states, IDLE, SETUP, ACCESS and DONE, with all outputs registered.
REQ-004 In IDLE with any req_i bit high, the block SHALL select a winner, latch its addr/wdata/wr into PADDR/PWDATA/PWRITE, and enter SETUP on the next edge.
REQ-005 Arbitration SHALL be two-way round-robin: a single request wins outright; when both are high, requester ptr wins.
REQ-006 ptr SHALL flip to the other requester after every DONE or abort, whichever requester won.
REQ-007 In SETUP the bus SHALL drive PSELx=1 and PENABLE=0, then enter ACCESS unconditionally.
REQ-008 In ACCESS the bus SHALL drive PSELx=1 and PENABLE=1; PADDR, PWDATA and PWRITE SHALL be held stable from SETUP until ACCESS exits.
REQ-009 In ACCESS with PREADY=1 the block SHALL:
- enter DONE;
- for a read, capture PRDATA into rdata_o;
- for a write, leave rdata_o unchanged.
REQ-010 In DONE, done_o[winner] SHALL be 1 for exactly one cycle, PSELx=PENABLE=0, req_i SHALL be ignored, and the next state SHALL be IDLE.
REQ-011 Latency SHALL be: req sampled in IDLE at edge k -> SETUP cycle k+1 -> ACCESS k+2 -> done_o high in cycle k+3 when PREADY=1 immediately, plus one cycle per PREADY-low cycle.
REQ-012 The wait counter SHALL clear on ACCESS entry and increment on each ACCESS cycle with PREADY=0.
REQ-013 When the wait counter reaches TIMEOUT_CYC, the block SHALL drop PSELx and PENABLE, pulse err_o[winner] for one cycle (done_o stays 0, rdata_o unchanged), flip ptr, and return to IDLE.
REQ-014 Requesters SHALL hold req_i and their operands until done_o or err_o; changes mid-transfer SHALL NOT affect the bus.
REQ-015 A req_i still high in the IDLE following DONE or abort SHALL be treated as a new request.
REQ-016 At most one bit of done_o|err_o SHALL be high in any cycle.
REQ-017 A PREADY=1 in IDLE, SETUP or DONE SHALL be ignored.

Reset
REQ-018 PRESET=1 at a PCLK edge SHALL force, on that edge: state=IDLE; ptr=0; wait counter=0; PSELx=0; PENABLE=0; PWRITE=0; PADDR=0; PWDATA=0; rdata_o=0; done_o=0; err_o=0.
REQ-019 Reset asserted mid-transfer SHALL abandon the transfer with no done_o or err_o pulse.

Structure
REQ-020 Package apb_arb_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS, DONE) and the default DATA_WIDTH, ADDR_WIDTH and TIMEOUT_CYC constants.
REQ-021 Round-robin selection SHALL be a sub-module apb_rr_pick (inputs req[1:0] and ptr; output one-hot grant), instantiated once.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single write: req_i=01, wr_i=01, addr0=0x155, wdata0=0xA5, PREADY=1 -> SETUP then ACCESS with PADDR=0x155, PWDATA=0xA5, PWRITE=1; done_o=01 three cycles after the request.
- Read with 2 wait states: req_i=10, addr1=0x3FF, PRDATA=0x5C at ready -> ACCESS lasts 3 cycles; rdata_o=0x5C; done_o=10.
- Contention: req_i=11 held after reset -> grant order 0,1,0,1; one IDLE and one DONE cycle between transfers; no simultaneous done bits.
- Timeout: PREADY=0 forever -> after 16 ACCESS cycles PSELx drops, err_o=01, done_o=00, rdata_o unchanged; the next grant goes to requester 1.
- Reset mid-ACCESS: PRESET=1 for one cycle during the wait -> PSELx=0 next cycle; no done or err pulse; ptr=0.
- Operand change mid-transfer: flip addr0 during SETUP -> PADDR holds the value latched in IDLE.
